// File: rtl/fifo_pkg.sv
// Shared constants, prefetch state type and sizing helper for the single-clock FIFO family.
package fifo_pkg;

    localparam string SHOW_AHEAD_ON   = "ON";
    localparam string SHOW_AHEAD_OFF  = "OFF";
    localparam string MEM_BLOCK       = "BLOCK";
    localparam string MEM_DISTRIBUTED = "DISTRIBUTED";

    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_FETCH = 2'd1,
        PF_VALID = 2'd2
    } pf_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM with one write port and an enabled, registered read port.
// The read register doubles as the FIFO output register, so it is resettable.
module sync_fifo_mem import fifo_pkg::*; #(
    parameter int    WIDTH    = 8,
    parameter int    DEPTH    = 8,
    parameter string MEM_TYPE = MEM_BLOCK,
    parameter int    AW       = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] rdata_q;

    assign rdata = rdata_q;

    if (MEM_TYPE == MEM_DISTRIBUTED) begin : g_dist
        (* ram_style = "distributed" *) logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (rst) begin
                rdata_q <= '0;
            end else if (re) begin
                rdata_q <= mem[raddr];
            end
        end
    end else begin : g_block
        (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            if (rst) begin
                rdata_q <= '0;
            end else if (re) begin
                rdata_q <= mem[raddr];
            end
        end
    end

endmodule

// File: rtl/sync_fifo_pro.sv
// Single-clock FIFO with exact depth, standard or show-ahead output,
// occupancy count, threshold flags and overflow/underflow pulses.
module sync_fifo_pro import fifo_pkg::*; #(
    parameter int    FIFO_WITH   = 8,
    parameter int    FIFO_DEPTH  = 8,
    parameter string SHOW_AHAEAD = SHOW_AHEAD_OFF,
    parameter string MEM_TYPE    = MEM_BLOCK,
    parameter int    AF_LEVEL    = FIFO_DEPTH - 1,
    parameter int    AE_LEVEL    = 1,
    localparam int   CNT_W       = clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [FIFO_WITH-1:0] wr_data,
    output logic                 fifo_full,
    output logic                 fifo_almost_full,
    output logic                 overflow,
    input  logic                 rd_en,
    output logic [FIFO_WITH-1:0] rd_data,
    output logic                 fifo_empty,
    output logic                 fifo_almost_empty,
    output logic                 underflow,
    output logic [CNT_W-1:0]     fifo_level
);

    localparam int               PTR_W    = clog2(FIFO_DEPTH);
    localparam bit               SA_ON    = (SHOW_AHAEAD == SHOW_AHEAD_ON);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d, mem_cnt, mem_cnt_d;
    pf_state_e        state_q, state_d;
    logic             full_q, full_d, af_q, af_d, empty_q, empty_d, ae_q, ae_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;
    logic             wr_acc, rd_acc, ram_re;

    always_comb begin
        wr_acc = wr_en & ~full_q & ~rst;
        rd_acc = rd_en & ~empty_q & ~rst;
        // Words still in RAM: the level minus the one parked in the output register.
        mem_cnt = (SA_ON && state_q == PF_VALID) ? level_q - CNT_W'(1) : level_q;
        if (SA_ON) begin
            ram_re = ~rst & ((state_q == PF_FETCH) |
                             ((state_q == PF_VALID) & rd_acc & (mem_cnt != '0)));
        end else begin
            ram_re = rd_acc;
        end

        level_d = level_q;
        if (wr_acc && !rd_acc) begin
            level_d = level_q + CNT_W'(1);
        end else if (rd_acc && !wr_acc) begin
            level_d = level_q - CNT_W'(1);
        end

        wr_ptr_d  = wr_acc ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d  = ram_re ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        mem_cnt_d = mem_cnt + CNT_W'(wr_acc) - CNT_W'(ram_re);

        state_d = state_q;
        case (state_q)
            PF_IDLE:  if (mem_cnt_d != '0) state_d = PF_FETCH;
            PF_FETCH: state_d = PF_VALID;
            PF_VALID: begin
                // A word written in the pop cycle cannot be read back until the next cycle.
                if (rd_acc) begin
                    state_d = ram_re ? PF_VALID : ((mem_cnt_d != '0) ? PF_FETCH : PF_IDLE);
                end
            end
            default:  state_d = PF_IDLE;
        endcase
        if (!SA_ON) begin
            state_d = PF_IDLE;
        end

        empty_d = SA_ON ? (state_d != PF_VALID) : (level_d == '0);
        full_d  = (level_d == DEPTH_C);
        af_d    = (level_d >= AF_C);
        ae_d    = (level_d <= AE_C);
        ovf_d   = wr_en & full_q;
        udf_d   = rd_en & empty_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= PF_IDLE;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            empty_q  <= 1'b1;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            full_q   <= full_d;
            af_q     <= af_d;
            empty_q  <= empty_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    sync_fifo_mem #(
        .WIDTH    (FIFO_WITH),
        .DEPTH    (FIFO_DEPTH),
        .MEM_TYPE (MEM_TYPE),
        .AW       (PTR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (ram_re),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    assign fifo_full         = full_q;
    assign fifo_almost_full  = af_q;
    assign overflow          = ovf_q;
    assign fifo_empty        = empty_q;
    assign fifo_almost_empty = ae_q;
    assign underflow         = udf_q;
    assign fifo_level        = level_q;

endmodule

// File: tb/tb_sync_fifo_pro.sv
// Bench for sync_fifo_pro: one standard-mode and one show-ahead instance, each
// checked against a queue model of the FIFO's externally visible behaviour.
module tb_sync_fifo_pro;

    localparam int W  = 8;
    localparam int D  = 6;
    localparam int AF = 5;
    localparam int AE = 1;
    localparam int OW = 6 + 3 + W;
    localparam logic [OW-1:0] RST_OBS = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         s_rst = 1'b0, s_wr_en = 1'b0, s_rd_en = 1'b0;
    logic [W-1:0] s_wr_data = '0, s_rd_data;
    logic         s_full, s_af, s_ovf, s_empty, s_ae, s_udf;
    logic [2:0]   s_level;
    logic         a_rst = 1'b0, a_wr_en = 1'b0, a_rd_en = 1'b0;
    logic [W-1:0] a_wr_data = '0, a_rd_data;
    logic         a_full, a_af, a_ovf, a_empty, a_ae, a_udf;
    logic [2:0]   a_level;
    logic [OW-1:0] s_obs, a_obs, s_exp, a_exp;

    assign s_obs = {s_full, s_af, s_ovf, s_empty, s_ae, s_udf, s_level, s_rd_data};
    assign a_obs = {a_full, a_af, a_ovf, a_empty, a_ae, a_udf, a_level, a_rd_data};

    sync_fifo_pro #(.FIFO_WITH(W), .FIFO_DEPTH(D), .SHOW_AHAEAD("OFF"), .MEM_TYPE("BLOCK"),
                    .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_std (
        .clk(clk), .rst(s_rst), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .fifo_full(s_full), .fifo_almost_full(s_af), .overflow(s_ovf),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .fifo_empty(s_empty),
        .fifo_almost_empty(s_ae), .underflow(s_udf), .fifo_level(s_level)
    );

    sync_fifo_pro #(.FIFO_WITH(W), .FIFO_DEPTH(D), .SHOW_AHAEAD("ON"), .MEM_TYPE("DISTRIBUTED"),
                    .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_sa (
        .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_data(a_wr_data),
        .fifo_full(a_full), .fifo_almost_full(a_af), .overflow(a_ovf),
        .rd_en(a_rd_en), .rd_data(a_rd_data), .fifo_empty(a_empty),
        .fifo_almost_empty(a_ae), .underflow(a_udf), .fifo_level(a_level)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Standard-mode model: stored words, last word handed out, error pulses.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] s_last = '0;
    logic         s_eovf = 1'b0, s_eudf = 1'b0;
    // Show-ahead model: stored words with the edge they were written on.
    logic [W-1:0] exp_sa_q[$];
    int           exp_sa_t[$];
    logic [W-1:0] a_last = '0;
    logic         a_eovf = 1'b0, a_eudf = 1'b0;
    int           a_pop_edge = 0;
    int           edge_n = 0;

    // The head is presented one edge after it was written, and never before
    // the edge that popped its predecessor.
    function automatic bit a_visible(input int at_edge);
        int ready;
        if (exp_sa_q.size() == 0) return 1'b0;
        ready = exp_sa_t[0] + 1;
        if (a_pop_edge > ready) ready = a_pop_edge;
        return ready <= at_edge;
    endfunction

    task automatic step(input logic sw, input logic [W-1:0] sd, input logic sr,
                        input logic aw, input logic [W-1:0] ad, input logic ar);
        int n;
        bit vis;
        s_wr_en = sw; s_wr_data = sd; s_rd_en = sr;
        a_wr_en = aw; a_wr_data = ad; a_rd_en = ar;
        n = exp_q.size();
        if (s_rst) begin
            exp_q.delete(); s_last = '0; s_eovf = 1'b0; s_eudf = 1'b0;
        end else begin
            s_eovf = sw && (n == D);
            s_eudf = sr && (n == 0);
            if (sr && n > 0) s_last = exp_q.pop_front();
            if (sw && n < D) exp_q.push_back(sd);
        end
        vis = a_visible(edge_n);
        n = exp_sa_q.size();
        edge_n++;
        if (a_rst) begin
            exp_sa_q.delete(); exp_sa_t.delete();
            a_last = '0; a_eovf = 1'b0; a_eudf = 1'b0; a_pop_edge = 0;
        end else begin
            a_eovf = aw && (n == D);
            a_eudf = ar && !vis;
            if (ar && vis) begin
                a_last = exp_sa_q.pop_front();
                void'(exp_sa_t.pop_front());
                a_pop_edge = edge_n;
            end
            if (aw && n < D) begin
                exp_sa_q.push_back(ad);
                exp_sa_t.push_back(edge_n);
            end
        end
        @(posedge clk);
        #1;
        n = exp_q.size();
        s_exp = {n == D, n >= AF, s_eovf, n == 0, n <= AE, s_eudf, 3'(n), s_last};
        n = exp_sa_q.size();
        vis = a_visible(edge_n);
        a_exp = {n == D, n >= AF, a_eovf, !vis, n <= AE, a_eudf, 3'(n),
                 vis ? exp_sa_q[0] : a_last};
    endtask

    task automatic s_step(input logic w, input logic [W-1:0] d, input logic r);
        step(w, d, r, 1'b0, '0, 1'b0);
    endtask

    task automatic a_step(input logic w, input logic [W-1:0] d, input logic r);
        step(1'b0, '0, 1'b0, w, d, r);
    endtask

    task automatic test_reset();
        s_rst = 1'b1; a_rst = 1'b1;
        step(1'b1, 8'hAB, 1'b1, 1'b1, 8'hCD, 1'b1);
        s_rst = 1'b0; a_rst = 1'b0;
        n_cmp++;
        if (s_obs !== RST_OBS) begin
            n_fail++; $display("FAIL reset_std: got %h want %h", s_obs, RST_OBS);
        end
        n_cmp++;
        if (a_obs !== RST_OBS) begin
            n_fail++; $display("FAIL reset_sa: got %h want %h", a_obs, RST_OBS);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < D; i++) begin
            s_step(1'b1, 8'(8'h11 + i), 1'b0);
            n_cmp++;
            if (s_obs !== s_exp || s_level !== 3'(i + 1) || s_af !== (i + 1 >= AF)) begin
                n_fail++; $display("FAIL fill[%0d]: got %h want %h", i, s_obs, s_exp);
            end
        end
        n_cmp++;
        if (s_full !== 1'b1) begin
            n_fail++; $display("FAIL fill_full: got %b want 1", s_full);
        end
        s_step(1'b1, 8'h77, 1'b0);
        n_cmp++;
        if (s_obs !== s_exp || s_ovf !== 1'b1 || s_level !== 3'd6) begin
            n_fail++; $display("FAIL overflow: got %h want %h", s_obs, s_exp);
        end
        s_step(1'b0, '0, 1'b0);
        n_cmp++;
        if (s_ovf !== 1'b0 || s_level !== 3'd6) begin
            n_fail++; $display("FAIL overflow_pulse: got ovf %b lvl %0d want 0 6", s_ovf, s_level);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 7; i++) begin
            s_step(1'b0, '0, 1'b1);
            n_cmp++;
            if (s_obs !== s_exp || s_rd_data !== 8'(8'h11 + ((i < 6) ? i : 5))) begin
                n_fail++; $display("FAIL drain[%0d]: got %h want %h", i, s_obs, s_exp);
            end
        end
        n_cmp++;
        if (s_udf !== 1'b1 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_rd_data !== 8'h16) begin
            n_fail++; $display("FAIL underflow: got udf %b empty %b rd %h want 1 1 16",
                               s_udf, s_empty, s_rd_data);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 4; i++) s_step(1'b1, 8'(i + 1), 1'b0);
        for (int i = 0; i < 4; i++) s_step(1'b0, '0, 1'b1);
        for (int i = 0; i < D; i++) s_step(1'b1, 8'(8'hA0 + i), 1'b0);
        n_cmp++;
        if (s_obs !== s_exp || s_level !== 3'd6) begin
            n_fail++; $display("FAIL wrap_fill: got %h want %h", s_obs, s_exp);
        end
        for (int i = 0; i < D; i++) begin
            s_step(1'b0, '0, 1'b1);
            n_cmp++;
            if (s_obs !== s_exp || s_rd_data !== 8'(8'hA0 + i)) begin
                n_fail++; $display("FAIL wrap_read[%0d]: got %h want %h", i, s_obs, s_exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) s_step(1'b1, 8'(8'h30 + i), 1'b0);
        s_step(1'b1, 8'h33, 1'b1);
        n_cmp++;
        if (s_obs !== s_exp || s_level !== 3'd3) begin
            n_fail++; $display("FAIL simul_mid: got %h want %h", s_obs, s_exp);
        end
        for (int i = 0; i < 3; i++) s_step(1'b1, 8'(8'h40 + i), 1'b0);
        s_step(1'b1, 8'h4F, 1'b1);
        n_cmp++;
        if (s_obs !== s_exp || s_level !== 3'd5 || s_ovf !== 1'b1) begin
            n_fail++; $display("FAIL simul_full: got %h want %h", s_obs, s_exp);
        end
        for (int i = 0; i < 5; i++) s_step(1'b0, '0, 1'b1);
        s_step(1'b1, 8'h5A, 1'b1);
        n_cmp++;
        if (s_obs !== s_exp || s_level !== 3'd1 || s_udf !== 1'b1) begin
            n_fail++; $display("FAIL simul_empty: got %h want %h", s_obs, s_exp);
        end
        s_step(1'b0, '0, 1'b1);
        n_cmp++;
        if (s_obs !== s_exp || s_rd_data !== 8'h5A) begin
            n_fail++; $display("FAIL simul_drain: got %h want %h", s_obs, s_exp);
        end
    endtask

    task automatic test_show_ahead();
        a_step(1'b1, 8'h3C, 1'b0);
        n_cmp++;
        if (a_obs !== a_exp || a_empty !== 1'b1) begin
            n_fail++; $display("FAIL sa_latency1: got %h want %h", a_obs, a_exp);
        end
        a_step(1'b0, '0, 1'b0);
        n_cmp++;
        if (a_obs !== a_exp || a_empty !== 1'b0 || a_rd_data !== 8'h3C) begin
            n_fail++; $display("FAIL sa_latency2: got %h want %h", a_obs, a_exp);
        end
        a_step(1'b1, 8'h3D, 1'b0);
        a_step(1'b0, '0, 1'b1);
        n_cmp++;
        if (a_obs !== a_exp || a_rd_data !== 8'h3D || a_empty !== 1'b0) begin
            n_fail++; $display("FAIL sa_pop1: got %h want %h", a_obs, a_exp);
        end
        a_step(1'b0, '0, 1'b1);
        n_cmp++;
        if (a_obs !== a_exp || a_empty !== 1'b1 || a_level !== 3'd0) begin
            n_fail++; $display("FAIL sa_pop2: got %h want %h", a_obs, a_exp);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 5; i++) a_step(1'b1, 8'(8'hC0 + i), 1'b0);
        a_step(1'b0, '0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            a_step(1'b0, '0, 1'b1);
            n_cmp++;
            if (a_obs !== a_exp || a_rd_data !== 8'(8'hC0 + i) || a_empty !== 1'b0) begin
                n_fail++; $display("FAIL b2b[%0d]: got %h want %h", i, a_obs, a_exp);
            end
        end
        a_step(1'b0, '0, 1'b1);
        n_cmp++;
        if (a_obs !== a_exp || a_empty !== 1'b1) begin
            n_fail++; $display("FAIL b2b_end: got %h want %h", a_obs, a_exp);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
        s_rst = 1'b1; a_rst = 1'b1;
        step(1'b1, 8'h99, 1'b0, 1'b1, 8'h98, 1'b0);
        s_rst = 1'b0; a_rst = 1'b0;
        n_cmp++;
        if (s_obs !== RST_OBS || a_obs !== RST_OBS) begin
            n_fail++; $display("FAIL reset_mid: got %h/%h want %h", s_obs, a_obs, RST_OBS);
        end
        step(1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        n_cmp++;
        if (s_obs !== s_exp || s_rd_data !== 8'h55 || s_empty !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_std: got %h want %h", s_obs, s_exp);
        end
        n_cmp++;
        if (a_obs !== a_exp || a_rd_data !== 8'h55 || a_empty !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_sa: got %h want %h", a_obs, a_exp);
        end
        a_step(1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        int wp = 50;
        int rp = 50;
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) begin
                wp = $urandom_range(5, 95);
                rp = $urandom_range(5, 95);
            end
            s_rst = ($urandom_range(0, 249) == 0);
            a_rst = ($urandom_range(0, 249) == 0);
            step(($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < rp),
                 ($urandom_range(0, 99) < wp), 8'($urandom), ($urandom_range(0, 99) < rp));
            s_rst = 1'b0; a_rst = 1'b0;
            n_cmp++;
            if (s_obs !== s_exp) begin
                n_fail++; $display("FAIL rand_std[%0d]: got %h want %h", i, s_obs, s_exp);
            end
            n_cmp++;
            if (a_obs !== a_exp) begin
                n_fail++; $display("FAIL rand_sa[%0d]: got %h want %h", i, a_obs, a_exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_show_ahead();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
